// File: rtl/abs_pipe.sv
// Two-stage abs/neg/pass/nabs pipeline with valid/ready handshakes,
// optional saturation on overflow and a saturating overflow counter.
module abs_pipe #(
  parameter int WIDTH = 32,
  parameter int SAT   = 0,
  parameter int CNTW  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf,
  output logic [CNTW-1:0]  ovf_count,
  input  logic             clr_count
);

  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] MAX_VAL = {1'b0, {(WIDTH-1){1'b1}}};

  localparam logic [1:0] OP_ABS  = 2'b00;
  localparam logic [1:0] OP_NEG  = 2'b01;
  localparam logic [1:0] OP_PASS = 2'b10;
  localparam logic [1:0] OP_NABS = 2'b11;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_x;
  logic             s1_cin;
  logic             s1_ovf;
  logic             s2_valid;
  logic [WIDTH-1:0] s2_data;
  logic             s2_ovf;

  logic             s1_adv;
  logic             m_on;
  logic             ovf_in;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] result;

  assign s1_adv   = !s2_valid || out_ready;
  assign in_ready = rst_n && (!s1_valid || s1_adv);

  // Mask selection: negate negatives for abs, always for neg, positives for nabs
  always_comb begin
    m_on   = 1'b0;
    ovf_in = 1'b0;
    case (in_op)
      OP_ABS:  m_on = in_data[WIDTH-1];
      OP_NEG:  m_on = 1'b1;
      OP_PASS: m_on = 1'b0;
      OP_NABS: m_on = !in_data[WIDTH-1] && (in_data != '0);
      default: m_on = 1'b0;
    endcase
    if ((in_op == OP_ABS || in_op == OP_NEG) && in_data == MIN_VAL)
      ovf_in = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_x     <= '0;
      s1_cin   <= 1'b0;
      s1_ovf   <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_x   <= in_data ^ {WIDTH{m_on}};
        s1_cin <= m_on;
        s1_ovf <= ovf_in;
      end
    end
  end

  assign sum    = s1_x + {{(WIDTH-1){1'b0}}, s1_cin};
  assign result = (SAT != 0 && s1_ovf) ? MAX_VAL : sum;

  // Stage 2 only moves when the output slot is empty or being drained
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_ovf   <= 1'b0;
    end else if (s1_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_data <= result;
        s2_ovf  <= s1_ovf;
      end
    end
  end

  assign out_valid = s2_valid;
  assign out_data  = s2_data;
  assign out_ovf   = s2_ovf;

  // Clear wins over a coincident increment; the count sticks at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ovf_count <= '0;
    else if (clr_count)
      ovf_count <= '0;
    else if (s2_valid && out_ready && s2_ovf && ovf_count != '1)
      ovf_count <= ovf_count + 1'b1;
  end

endmodule

// File: tb/tb_abs_pipe.sv
// Directed bench for abs_pipe: three instances (wrap, saturate, 2-bit counter)
// share one stimulus stream and are checked against hand-computed values.
module tb_abs_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_data;
  logic [1:0]  in_op;
  logic        out_ready;
  logic        clr_count;

  logic        in_ready0, in_ready1, in_ready2;
  logic        out_valid0, out_valid1, out_valid2;
  logic [31:0] out_data0, out_data1, out_data2;
  logic        out_ovf0, out_ovf1, out_ovf2;
  logic [15:0] ovf_count0, ovf_count1;
  logic [1:0]  ovf_count2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  abs_pipe #(.WIDTH(32), .SAT(0), .CNTW(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .in_data(in_data), .in_op(in_op), .out_valid(out_valid0), .out_ready(out_ready),
    .out_data(out_data0), .out_ovf(out_ovf0), .ovf_count(ovf_count0), .clr_count(clr_count));

  abs_pipe #(.WIDTH(32), .SAT(1), .CNTW(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .in_data(in_data), .in_op(in_op), .out_valid(out_valid1), .out_ready(out_ready),
    .out_data(out_data1), .out_ovf(out_ovf1), .ovf_count(ovf_count1), .clr_count(clr_count));

  abs_pipe #(.WIDTH(32), .SAT(0), .CNTW(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .in_data(in_data), .in_op(in_op), .out_valid(out_valid2), .out_ready(out_ready),
    .out_data(out_data2), .out_ovf(out_ovf2), .ovf_count(ovf_count2), .clr_count(clr_count));

  // Present one beat on an idle pipe and return dut0/dut1 outputs two cycles later
  task automatic drive_beat(input logic [31:0] d, input logic [1:0] op,
                            output logic v, output logic [31:0] r0, output logic o0,
                            output logic [31:0] r1, output logic o1);
    in_valid = 1'b1;
    in_data  = d;
    in_op    = op;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 32'hDEAD_BEEF;
    in_op    = 2'b01;
    @(negedge clk);
    v  = out_valid0;
    r0 = out_data0;
    o0 = out_ovf0;
    r1 = out_data1;
    o1 = out_ovf1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_op = '0;
    out_ready = 1'b1; clr_count = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid0 !== 1'b0 || out_data0 !== 32'h0 || out_ovf0 !== 1'b0 || ovf_count0 !== 16'h0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: valid=%b data=%h ovf=%b cnt=%0d, required 0/0/0/0",
               out_valid0, out_data0, out_ovf0, ovf_count0);
    end
    checks++;
    if (in_ready0 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_in_ready: got %b, required 0", in_ready0);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready0 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL release_in_ready: got %b, required 1", in_ready0);
    end
  endtask

  task automatic test_abs_basic();
    logic [31:0] vin [3] = '{32'hFFFF_FFFF, 32'h0000_0005, 32'h0000_0000};
    logic [1:0]  opv [3] = '{2'b00, 2'b00, 2'b11};
    logic [31:0] exp [3] = '{32'h0000_0001, 32'h0000_0005, 32'h0000_0000};
    logic v, o0, o1;
    logic [31:0] r0, r1;
    for (int i = 0; i < 3; i++) begin
      drive_beat(vin[i], opv[i], v, r0, o0, r1, o1);
      checks++;
      if (v !== 1'b1 || r0 !== exp[i] || o0 !== 1'b0) begin
        errors++;
        $display("[TB] FAIL abs_basic_%0d: valid=%b data=%h ovf=%b, required 1/%h/0",
                 i, v, r0, o0, exp[i]);
      end
    end
  endtask

  task automatic test_min();
    logic v, o0, o1;
    logic [31:0] r0, r1;
    drive_beat(32'h8000_0000, 2'b00, v, r0, o0, r1, o1);
    checks++;
    if (v !== 1'b1 || r0 !== 32'h8000_0000 || o0 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL min_abs_wrap: valid=%b data=%h ovf=%b, required 1/80000000/1", v, r0, o0);
    end
    checks++;
    if (r1 !== 32'h7FFF_FFFF || o1 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL min_abs_sat: data=%h ovf=%b, required 7fffffff/1", r1, o1);
    end
    @(negedge clk);
    checks++;
    if (ovf_count0 !== 16'd1 || ovf_count1 !== 16'd1) begin
      errors++;
      $display("[TB] FAIL min_count: got %0d/%0d, required 1/1", ovf_count0, ovf_count1);
    end
    drive_beat(32'h8000_0000, 2'b11, v, r0, o0, r1, o1);
    checks++;
    if (r0 !== 32'h8000_0000 || o0 !== 1'b0 || r1 !== 32'h8000_0000 || o1 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL min_nabs: data=%h/%h ovf=%b/%b, required 80000000/80000000 0/0",
               r0, r1, o0, o1);
    end
    drive_beat(32'h8000_0000, 2'b01, v, r0, o0, r1, o1);
    checks++;
    if (r0 !== 32'h8000_0000 || o0 !== 1'b1 || r1 !== 32'h7FFF_FFFF || o1 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL min_neg: data=%h/%h ovf=%b/%b, required 80000000/7fffffff 1/1",
               r0, r1, o0, o1);
    end
    @(negedge clk);
  endtask

  task automatic test_ops();
    logic [31:0] vin [4] = '{32'h0000_0007, 32'h0000_0007, 32'h0000_0007, 32'hFFFF_FFF9};
    logic [1:0]  opv [4] = '{2'b01, 2'b11, 2'b10, 2'b11};
    logic [31:0] exp [4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'h0000_0007, 32'hFFFF_FFF9};
    logic v, o0, o1;
    logic [31:0] r0, r1;
    for (int i = 0; i < 4; i++) begin
      drive_beat(vin[i], opv[i], v, r0, o0, r1, o1);
      checks++;
      if (v !== 1'b1 || r0 !== exp[i] || o0 !== 1'b0 || r1 !== exp[i]) begin
        errors++;
        $display("[TB] FAIL ops_%0d: valid=%b data=%h/%h ovf=%b, required 1/%h/0",
                 i, v, r0, r1, o0, exp[i]);
      end
    end
  endtask

  task automatic test_counter();
    logic [1:0] exp2 [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    logic v, o0, o1;
    logic [31:0] r0, r1;
    clr_count = 1'b1;
    @(negedge clk);
    clr_count = 1'b0;
    checks++;
    if (ovf_count0 !== 16'd0 || ovf_count2 !== 2'd0) begin
      errors++;
      $display("[TB] FAIL count_clear: got %0d/%0d, required 0/0", ovf_count0, ovf_count2);
    end
    for (int i = 0; i < 5; i++) begin
      drive_beat(32'h8000_0000, 2'b00, v, r0, o0, r1, o1);
      @(negedge clk);
      checks++;
      if (ovf_count2 !== exp2[i] || ovf_count0 !== 16'(i + 1)) begin
        errors++;
        $display("[TB] FAIL count_step_%0d: got %0d/%0d, required %0d/%0d",
                 i, ovf_count2, ovf_count0, exp2[i], i + 1);
      end
    end
    drive_beat(32'h8000_0000, 2'b00, v, r0, o0, r1, o1);
    clr_count = 1'b1;
    @(negedge clk);
    clr_count = 1'b0;
    checks++;
    if (ovf_count2 !== 2'd0 || ovf_count0 !== 16'd0) begin
      errors++;
      $display("[TB] FAIL count_clr_priority: got %0d/%0d, required 0/0", ovf_count2, ovf_count0);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] vin [4] = '{32'hFFFF_FFF0, 32'h0000_0011, 32'h0000_0022, 32'h0000_0033};
    logic [1:0]  opv [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
    logic [31:0] exp [4] = '{32'h0000_0010, 32'hFFFF_FFEF, 32'h0000_0022, 32'hFFFF_FFCD};
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (c >= 2) begin
        checks++;
        if (out_valid0 !== 1'b1 || out_data0 !== exp[c-2]) begin
          errors++;
          $display("[TB] FAIL b2b_%0d: valid=%b data=%h, required 1/%h",
                   c - 2, out_valid0, out_data0, exp[c-2]);
        end
      end
      in_valid = (c < 4);
      in_data  = (c < 4) ? vin[c] : 32'h0;
      in_op    = (c < 4) ? opv[c] : 2'b00;
      @(negedge clk);
    end
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [31:0] vin [8] = '{32'hFFFF_FFFE, 32'h0000_0003, 32'h0000_0010, 32'h0000_0020,
                             32'hFFFF_FF00, 32'h0000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF};
    logic [1:0]  opv [8] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b01, 2'b01, 2'b00};
    logic [31:0] exp [8] = '{32'h0000_0002, 32'hFFFF_FFFD, 32'h0000_0010, 32'hFFFF_FFE0,
                             32'h0000_0100, 32'h0000_0000, 32'h0000_0001, 32'h7FFF_FFFF};
    int sent = 0, recv = 0, occ = 0;
    logic hold_pend = 1'b0;
    logic [31:0] held = '0;
    logic rdy_exp, acc, take;
    for (int c = 0; c < 200 && recv < 8; c++) begin
      if (hold_pend) begin
        checks++;
        if (out_valid0 !== 1'b1 || out_data0 !== held) begin
          errors++;
          $display("[TB] FAIL stall_stable: valid=%b data=%h, required 1/%h", out_valid0, out_data0, held);
        end
      end
      out_ready = 1'($urandom_range(0, 1));
      in_valid  = (sent < 8);
      in_data   = (sent < 8) ? vin[sent] : 32'h0;
      in_op     = (sent < 8) ? opv[sent] : 2'b00;
      #1;
      rdy_exp = !(occ == 2 && !out_ready);
      checks++;
      if (in_ready0 !== rdy_exp) begin
        errors++;
        $display("[TB] FAIL bp_in_ready: got %b, required %b (occ=%0d)", in_ready0, rdy_exp, occ);
      end
      if (out_valid0 === 1'b1) begin
        checks++;
        if (out_data0 !== exp[recv]) begin
          errors++;
          $display("[TB] FAIL bp_order_%0d: got %h, required %h", recv, out_data0, exp[recv]);
        end
      end
      take      = (out_valid0 === 1'b1) && out_ready;
      acc       = in_valid && (in_ready0 === 1'b1);
      hold_pend = (out_valid0 === 1'b1) && !out_ready;
      held      = out_data0;
      if (take) recv++;
      if (acc) sent++;
      occ = occ + (acc ? 1 : 0) - (take ? 1 : 0);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (recv != 8) begin
      errors++;
      $display("[TB] FAIL bp_complete: received %0d beats, required 8", recv);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 32'hFFFF_FF9C; in_op = 2'b00;
    @(negedge clk);
    in_data = 32'h0000_0042; in_op = 2'b01;
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid0 !== 1'b0 || out_valid1 !== 1'b0 || out_data0 !== 32'h0) begin
      errors++;
      $display("[TB] FAIL midreset_flush: valid=%b/%b data=%h, required 0/0/0",
               out_valid0, out_valid1, out_data0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checks++;
      if (out_valid0 !== 1'b0 || out_valid2 !== 1'b0) begin
        errors++;
        $display("[TB] FAIL midreset_stale_%0d: valid=%b data=%h, required valid 0", c, out_valid0, out_data0);
      end
    end
  endtask

  initial begin
    test_reset();
    @(negedge clk);
    test_abs_basic();
    test_min();
    test_ops();
    test_counter();
    test_back_to_back();
    test_backpressure();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/abs_pipe.md
ABS_PIPE -- requirements
Module: abs_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits (legal range 2..64).
REQ-002 SHALL have parameter SAT, default 0; 0 = results wrap on overflow, 1 = results saturate on overflow.
REQ-003 SHALL have parameter CNTW, default 16, width of the overflow counter.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all flops are rising-edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port in_valid, input, 1 bit: operand presented.
REQ-007 SHALL have port in_ready, output, 1 bit: block accepts the operand this cycle.
REQ-008 SHALL have port in_data, input, WIDTH bits: two's-complement operand.
REQ-009 SHALL have port in_op, input, 2 bits: 00 = abs, 01 = neg, 10 = pass, 11 = nabs (negative absolute value).
REQ-010 SHALL have port out_valid, output, 1 bit: result available.
REQ-011 SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-012 SHALL have port out_data, output, WIDTH bits: result.
REQ-013 SHALL have port out_ovf, output, 1 bit: overflow occurred for this result.
REQ-014 SHALL have port ovf_count, output, CNTW bits: number of overflowed results delivered.
REQ-015 SHALL have port clr_count, input, 1 bit: synchronous clear of ovf_count.

Function
REQ-016 SHALL compute the conditional negation as (x XOR m) + (m AND 1). The mask m is all-ones when:
- abs and x is negative;
- neg (always);
- nabs and x is positive (non-zero, non-negative).
Otherwise m = 0.
REQ-017 SHALL flag overflow only for abs or neg with x = MIN (1 followed by WIDTH-1 zeros); pass, nabs and all other inputs never overflow.
REQ-018 SHALL, with SAT=0, output MIN on overflow; with SAT=1, output MAX (0 followed by WIDTH-1 ones).
REQ-019 SHALL use a two-stage pipeline:
- stage 1 registers (x XOR m), the carry-in and the overflow flag;
- stage 2 registers the sum, saturation and out_ovf.
Latency is 2 cycles from an accepted input to out_valid when there is no stall.
REQ-020 SHALL transfer a beat on the input when in_valid and in_ready are both 1, and on the output when out_valid and out_ready are both 1.
REQ-021 SHALL drive in_ready = NOT stage1_valid OR stage1_advances, where stage1_advances = NOT stage2_valid OR out_ready. Throughput is one beat per cycle under continuous out_ready=1.
REQ-022 SHALL hold out_data, out_ovf and out_valid stable while out_valid=1 and out_ready=0.
REQ-023 SHALL keep in_ready free of any combinational dependency on in_valid.
REQ-024 SHALL never drop, duplicate or reorder beats, and SHALL deliver beats in input order.
REQ-025 SHALL increment ovf_count by 1 on each output transfer with out_ovf=1, saturating at all-ones (no wrap).
REQ-026 SHALL give clr_count priority when it coincides with an increment: the count becomes 0 and the increment is lost.
REQ-027 SHALL ignore in_data and in_op when in_valid=0.

Reset
REQ-028 SHALL, while rst_n=0, force out_valid=0, out_data=0, out_ovf=0, ovf_count=0, and all stage valid flags to 0, independent of clk.
REQ-029 SHALL drive in_ready=0 while rst_n=0 and SHALL assert in_ready=1 in the first cycle after release.
REQ-030 SHALL discard in-flight beats when reset asserts mid-operation; no result from before reset appears afterwards.

Verification
REQ-031 Abs basics (WIDTH=32, out_ready=1): 0xFFFFFFFF abs -> 0x00000001 two cycles later; 0x00000005 abs -> 0x00000005; 0x00000000 nabs -> 0x00000000, out_ovf=0.
REQ-032 MIN handling: 0x80000000 abs with SAT=0 -> 0x80000000, out_ovf=1; with SAT=1 -> 0x7FFFFFFF, out_ovf=1; ovf_count=1 after each.
REQ-033 Ops on 0x00000007: neg -> 0xFFFFFFF9; nabs -> 0xFFFFFFF9; pass -> 0x00000007; 0xFFFFFFF9 nabs -> 0xFFFFFFF9.
REQ-034 Backpressure: stream 8 beats with out_ready toggling randomly -> all 8 results in order, values stable during stalls, in_ready=0 only when both stages are full and out_ready=0.
REQ-035 Counter: CNTW=2, 5 MIN abs beats -> ovf_count = 1, 2, 3, 3, 3; clr_count asserted in the same cycle as a MIN transfer -> ovf_count=0.
REQ-036 Reset mid-stream: assert rst_n=0 with 2 beats in flight -> out_valid=0 immediately; after release, no stale beat is ever output.
